// File: rtl/mem_access_unit.sv
// Initiator-side controller for a 32-bit big-endian byte-addressed RAM.
// Serves one byte/half/word load or store at a time; sub-word stores use read-modify-write.
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              Readmem,
  output logic              Writemem
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  // Big-endian lanes: the lowest byte address sits in the most significant bits.
  function automatic logic [4:0] f_lane_shift(input logic [1:0] sz, input logic [1:0] o);
    if (sz == SZ_HALF) return {~o[1], 4'b0000};
    return {~o, 3'b000};
  endfunction

  function automatic logic f_bad(input logic [1:0] sz, input logic [1:0] o);
    return (sz == 2'b11) || (sz == SZ_HALF && o[0]) || (sz == SZ_WORD && o != 2'b00);
  endfunction

  function automatic logic [DATA_W-1:0] f_load(input logic [DATA_W-1:0] word,
                                               input logic [1:0] sz,
                                               input logic [1:0] o,
                                               input logic sx);
    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = f_lane_shift(sz, o);
    case (sz)
      SZ_BYTE: begin
        b = word[sh +: 8];
        return {{24{sx & b[7]}}, b};
      end
      SZ_HALF: begin
        h = word[sh +: 16];
        return {{16{sx & h[15]}}, h};
      end
      default: return word;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] word,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [1:0] sz,
                                                input logic [1:0] o);
    logic [4:0]        sh;
    logic [DATA_W-1:0] mask;
    sh   = f_lane_shift(sz, o);
    mask = (sz == SZ_HALF) ? DATA_W'(16'hFFFF) : DATA_W'(8'hFF);
    return (word & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_rd;
  logic              r_wr;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sign_ext;
  logic [1:0]        r_off;
  logic [DATA_W-1:0] r_wdata;

  logic              w_accept;
  logic              w_bad;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merge;

  assign w_accept = (r_state == S_IDLE) && req;
  assign w_bad    = f_bad(size, addr[1:0]);
  assign w_load   = f_load(mem_rdata, r_size, r_off, r_sign_ext);
  assign w_merge  = f_merge(mem_rdata, r_wdata, r_size, r_off);

  // Request fields are frozen at acceptance so the core may move on immediately.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we       <= we;
      r_size     <= size;
      r_sign_ext <= sign_ext;
      r_off      <= addr[1:0];
      r_wdata    <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_busy     <= 1'b1;
            r_mem_addr <= {addr[ADDR_W-1:2], 2'b00};
            if (w_bad) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else if (we && size == SZ_WORD) begin
              r_state     <= S_WR;
              r_wr        <= 1'b1;
              r_mem_wdata <= wdata;
            end else begin
              r_state <= S_RD;
              r_rd    <= 1'b1;
            end
          end
        end
        S_RD: begin
          // RAM read is combinational, so the word is merged or extracted this cycle.
          if (r_we) begin
            r_state     <= S_WR;
            r_wr        <= 1'b1;
            r_mem_wdata <= w_merge;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_rdata <= w_load;
          end
        end
        S_WR: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign Readmem   = r_rd;
  assign Writemem  = r_wr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level memory model plus directed load/store/error/reset vectors.
module tb_mem_access_unit;

  localparam int K_ERR  = 0;
  localparam int K_LOAD = 1;
  localparam int K_WST  = 2;
  localparam int K_SST  = 3;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        Readmem;
  logic        Writemem;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .Readmem(Readmem), .Writemem(Writemem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] f_init_byte(input int i);
    return 8'(i) ^ 8'hA5;
  endfunction

  // RAM seen by the DUT
  logic [31:0] ram [64];
  bit ram_loaded = 1'b0;
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < 64; k++)
        ram[k] <= {f_init_byte(4*k), f_init_byte(4*k+1), f_init_byte(4*k+2), f_init_byte(4*k+3)};
      ram_loaded <= 1'b1;
    end else if (Writemem) begin
      ram[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory and per-request schedule
  logic [7:0]  mb [256];
  bit          m_loaded = 1'b0;
  int          m_left = 0;
  int          m_kind = K_ERR;
  logic [7:0]  m_base;
  logic        m_exp_err;
  logic [31:0] m_exp_rdata;
  logic [31:0] m_exp_word;

  function automatic int f_kind(input logic w, input logic [1:0] sz, input logic [7:0] a);
    if (sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)) return K_ERR;
    if (!w) return K_LOAD;
    if (sz == 2'd2) return K_WST;
    return K_SST;
  endfunction

  function automatic int f_lat(input int kind);
    case (kind)
      K_ERR:   return 1;
      K_SST:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int f_nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] f_exp_load(input logic [7:0] a, input logic [1:0] sz, input logic sx);
    int n;
    logic [31:0] v;
    n = f_nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mb[int'(a) + i]};
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
    return v;
  endfunction

  function automatic logic [31:0] f_exp_word(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [7:0] w [4];
    int n;
    int o;
    n = f_nbytes(sz);
    o = int'(a) % 4;
    for (int k = 0; k < 4; k++) w[k] = mb[int'(a) - o + k];
    for (int i = 0; i < n; i++) w[o+i] = wd[8*(n-1-i) +: 8];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!m_loaded) begin
      for (int i = 0; i < 256; i++) mb[i] <= f_init_byte(i);
      m_loaded <= 1'b1;
    end
    if (!reset_n) begin
      m_left <= 0;
    end else if (m_left > 0) begin
      if (m_left == 2 && (m_kind == K_WST || m_kind == K_SST))
        for (int k = 0; k < 4; k++) mb[int'(m_base) + k] <= m_exp_word[31-8*k -: 8];
      m_left <= m_left - 1;
    end else if (req) begin
      m_kind      <= f_kind(we, size, addr);
      m_left      <= f_lat(f_kind(we, size, addr));
      m_base      <= {addr[7:2], 2'b00};
      m_exp_err   <= (f_kind(we, size, addr) == K_ERR);
      m_exp_rdata <= (f_kind(we, size, addr) == K_LOAD) ? f_exp_load(addr, size, sign_ext) : 32'h0;
      m_exp_word  <= f_exp_word(addr, size, wdata);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_loaded) begin
      if (!reset_n) begin
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_Readmem", 32'(Readmem), 32'h0);
        chk("rst_Writemem", 32'(Writemem), 32'h0);
      end else begin
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("done", 32'(done), 32'(m_left == 1));
        chk("Readmem", 32'(Readmem),
            32'(m_left > 0 && m_left == f_lat(m_kind) && (m_kind == K_LOAD || m_kind == K_SST)));
        chk("Writemem", 32'(Writemem), 32'(m_left == 2 && (m_kind == K_WST || m_kind == K_SST)));
        chk("rd_wr_excl", 32'(Readmem & Writemem), 32'h0);
        chk("addr_align", 32'(mem_addr[1:0]), 32'h0);
        if (m_left > 0 && m_kind != K_ERR && m_left > 1)
          chk("mem_addr", 32'(mem_addr), 32'(m_base));
        if (m_left == 2 && (m_kind == K_WST || m_kind == K_SST))
          chk("mem_wdata", mem_wdata, m_exp_word);
        if (m_left == 1) begin
          chk("err", 32'(err), 32'(m_exp_err));
          if (m_kind == K_LOAD || m_kind == K_ERR) chk("rdata", rdata, m_exp_rdata);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic do_op(input string nm, input logic i_we, input logic [1:0] i_sz, input logic i_sx,
                       input logic [7:0] i_a, input logic [31:0] i_wd, input int exp_lat,
                       input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
    int n;
    wait_idle();
    req = 1'b1; we = i_we; size = i_sz; sign_ext = i_sx; addr = i_a; wdata = i_wd;
    @(posedge clk); #1;
    req = 1'b0; we = ~i_we; size = ~i_sz; sign_ext = ~i_sx; addr = ~i_a; wdata = ~i_wd;
    n = 1;
    while (!done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
    if (chk_rd) chk({nm, "_rdata"}, rdata, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0; addr = 8'h0; wdata = 32'h0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_Readmem", 32'(Readmem), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_op("st_word", 1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0);
    chk("ram_after_st_word", ram[4], 32'hDEADBEEF);
    do_op("ld_word", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 2, 1'b0, 1'b1, 32'hDEADBEEF);
    do_op("ld_b11_sx", 1'b0, 2'd0, 1'b1, 8'h11, 32'h0, 2, 1'b0, 1'b1, 32'hFFFFFFAD);
    do_op("ld_b11_zx", 1'b0, 2'd0, 1'b0, 8'h11, 32'h0, 2, 1'b0, 1'b1, 32'h000000AD);
    do_op("ld_b13_sx", 1'b0, 2'd0, 1'b1, 8'h13, 32'h0, 2, 1'b0, 1'b1, 32'hFFFFFFEF);
    do_op("ld_h12_zx", 1'b0, 2'd1, 1'b0, 8'h12, 32'h0, 2, 1'b0, 1'b1, 32'h0000BEEF);
    do_op("ld_h10_sx", 1'b0, 2'd1, 1'b1, 8'h10, 32'h0, 2, 1'b0, 1'b1, 32'hFFFFDEAD);

    do_op("st_b12", 1'b1, 2'd0, 1'b0, 8'h12, 32'h00000055, 3, 1'b0, 1'b0, 32'h0);
    chk("ram_after_st_b12", ram[4], 32'hDEAD55EF);
    do_op("st_h10", 1'b1, 2'd1, 1'b0, 8'h10, 32'h00001234, 3, 1'b0, 1'b0, 32'h0);
    chk("ram_after_st_h10", ram[4], 32'h123455EF);

    // Initial word at 0x20 is 0x85848786
    do_op("ld_b22_sx", 1'b0, 2'd0, 1'b1, 8'h22, 32'h0, 2, 1'b0, 1'b1, 32'hFFFFFF87);
    do_op("ld_h20_sx", 1'b0, 2'd1, 1'b1, 8'h20, 32'h0, 2, 1'b0, 1'b1, 32'hFFFF8584);
    do_op("st_b21", 1'b1, 2'd0, 1'b1, 8'h21, 32'hFFFFFF3C, 3, 1'b0, 1'b0, 32'h0);
    chk("ram_after_st_b21", ram[8], 32'h853C8786);
    do_op("st_h22", 1'b1, 2'd1, 1'b0, 8'h22, 32'hABCD9999, 3, 1'b0, 1'b0, 32'h0);
    chk("ram_after_st_h22", ram[8], 32'h853C9999);

    do_op("err_ld_w12", 1'b0, 2'd2, 1'b1, 8'h12, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    do_op("err_st_h13", 1'b1, 2'd1, 1'b0, 8'h13, 32'h11112222, 1, 1'b1, 1'b0, 32'h0);
    do_op("err_sz11", 1'b0, 2'd3, 1'b0, 8'h10, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    chk("ram_after_errs", ram[4], 32'h123455EF);

    // req held high across two different requests
    wait_idle();
    req = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 8'h10; wdata = 32'h0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 10);
    chk("held_a_lat", 32'(n), 32'd2);
    chk("held_a_rdata", rdata, 32'h123455EF);
    size = 2'd0; sign_ext = 1'b1; addr = 8'h13;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 10);
    chk("held_b_gap", 32'(n), 32'd3);
    chk("held_b_rdata", rdata, 32'hFFFFFFEF);
    req = 1'b0;

    // Reset during the read phase of a byte store
    wait_idle();
    req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 8'h12; wdata = 32'h00000077;
    @(posedge clk); #1;
    req = 1'b0;
    chk("mid_rmw_Readmem", 32'(Readmem), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_Readmem", 32'(Readmem), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_mem_addr", 32'(mem_addr), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ram_after_reset", ram[4], 32'h123455EF);
    do_op("post_rst_ld", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 2, 1'b0, 1'b1, 32'h123455EF);
    do_op("post_rst_st", 1'b1, 2'd0, 1'b0, 8'h11, 32'h000000AA, 3, 1'b0, 1'b0, 32'h0);
    chk("ram_after_post_rst_st", ram[4], 32'h12AA55EF);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side controller for the 32-bit big-endian, byte-addressed data RAM (ports address/data_in/data_out/Readmem/Writemem).
- Accepts one load or store request at a time from the core: byte, halfword or word, with optional sign extension on loads.
- Drives Readmem/Writemem with clean one-cycle strobes; performs read-modify-write for sub-word stores.
- Sits between the MEM pipeline stage and the RAM.

Parameters:
- ADDR_W, 8, RAM byte-address width.
- DATA_W, 32, word width; fixed at 32 (four byte lanes).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  1  request strobe, sampled only when busy=0
- we  in  1  1=store, 0=load
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  in  1  loads only: 1 sign-extends sub-word data, 0 zero-extends
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-justified for sub-word stores
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle completion pulse
- rdata  out  32  load result; valid while done=1, held until the next done
- err  out  1  with done: misaligned or illegal request
- mem_addr  out  ADDR_W  to RAM address, always word-aligned (low two bits 00)
- mem_wdata  out  32  to RAM data_in
- mem_rdata  in  32  from RAM data_out (combinational read)
- Readmem  out  1  RAM read enable, registered
- Writemem  out  1  RAM write enable, registered

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE immediately.
  - All outputs go to 0: busy, done, rdata, err, mem_addr, mem_wdata, Readmem, Writemem.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - When req=1, capture we/size/sign_ext/addr/wdata.
  - Set mem_addr to {addr[ADDR_W-1:2],2'b00}.
  - Misaligned or illegal request goes to DONE with err=1 and no RAM access. Cases: size=01 with addr[0]=1; size=10 with addr[1:0]≠00; size=11.
  - Load, or store with size≠10: go to RD with Readmem=1.
  - Word store: go to WR with Writemem=1 and mem_wdata=wdata.
- RD:
  - Readmem=1 for exactly one cycle. mem_rdata is captured at the end of the cycle.
  - Load: go to DONE.
  - Sub-word store: go to WR. mem_wdata = captured word with the target lane(s) replaced.
- WR: Writemem=1 for exactly one cycle; mem_addr and mem_wdata are stable throughout. Go to DONE.
- DONE: done=1 for one cycle. err reflects the request. Return to IDLE.
- Readmem and Writemem are never high together and never high in IDLE or DONE.
- Lane mapping (big-endian, o = addr[1:0]):
  - Byte: lane o occupies bits [31-8o -: 8].
  - Half: o=0 is [31:16], o=2 is [15:0].
- Load result: the selected lane is right-justified. Upper bits are filled with the lane MSB if sign_ext=1, else with 0. On err, rdata=0.
- Store merge: only the addressed byte or half changes; the other lanes keep their read value.
- Latency, counted from the accept edge to the done cycle:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- busy: high in RD, WR and DONE. req is ignored while busy=1, including during DONE. Back-to-back throughput is one request per (latency+1) cycles.
- Inputs may change after acceptance without affecting the operation in flight.
- Reset mid-operation: strobes drop asynchronously and the operation is abandoned with no done. A write already applied during WR is not rolled back.
- Address wrap: mem_addr is never within 3 of the top of the address space because it is aligned; no wrap handling is needed.

Test Plan:
- Word store then load: store addr=0x10, wdata=0xDEADBEEF, size=10.
  - Required: one Writemem cycle, mem_addr=0x10, done 2 cycles after accept.
  - Then load size=10, addr=0x10: rdata=0xDEADBEEF, err=0.
- Byte loads from the word 0xDEADBEEF at 0x10:
  - Byte addr=0x11, sign_ext=1: rdata=0xFFFFFFAD.
  - Same with sign_ext=0: rdata=0x000000AD.
  - Byte addr=0x13, sign_ext=1: rdata=0xFFFFFFEF.
  - Half addr=0x12, sign_ext=0: rdata=0x0000BEEF.
- Sub-word store RMW: word at 0x10=0xDEADBEEF; byte store addr=0x12, wdata=0x00000055.
  - Required sequence: one Readmem cycle, then one Writemem cycle with mem_wdata=0xDEAD55EF, then done 3 cycles after accept.
  - Half store addr=0x10, wdata=0x1234 gives 0x123455EF.
- Misaligned: load size=10 addr=0x12; store size=01 addr=0x13; size=11.
  - Required: done next cycle with err=1, rdata=0, and Readmem and Writemem both stay 0.
- Busy/ignore: hold req=1 continuously with two queued different requests.
  - Only one is accepted per transaction. The second is accepted in the first IDLE after DONE.
  - Readmem and Writemem are never both 1.
- Reset mid-RMW: assert reset_n=0 during RD of a byte store.
  - Required: all outputs 0 immediately, no Writemem, no done, and memory unchanged.
  - The next request after release completes normally.
